// File: rtl/lm32_dp_ram_reader.sv
// Purpose: streams a burst of words out of a registered-read dual-port RAM onto a valid/ready interface.
// Latency: start_i at edge N gives the first beat on valid_o from edge N+2; one beat per cycle with ready_i held high.
// Backpressure: reads are issued only while 3-entry FIFO occupancy plus the in-flight read is below 3, so a stalled consumer never loses data.
module lm32_dp_ram_reader #(
    parameter int addr_width = 32,
    parameter int data_width = 8,
    parameter int len_width  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [addr_width-1:0] base_i,
    input  logic [len_width-1:0]  len_i,
    output logic [addr_width-1:0] ram_raddr_o,
    input  logic [data_width-1:0] ram_rdata_i,
    output logic [data_width-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  busy_o,
    output logic                  done_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                state;
    logic [addr_width-1:0] cur_addr;
    logic [len_width-1:0]  remaining;
    logic                  in_flight;
    logic                  zero_pend;
    logic                  done_q;

    logic [data_width-1:0] fifo_mem [3];
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [1:0]            count;

    logic [2:0]            occupancy;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic [1:0]            count_nxt;
    logic                  drain_done;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Issue decision uses only registered occupancy, so ready_i never reaches the RAM address.
    always_comb begin
        occupancy  = {1'b0, count} + {2'b00, in_flight};
        issue      = (state == S_RUN) && (occupancy < 3'd3);
        push       = in_flight;
        pop        = valid_o && ready_i;
        count_nxt  = count + {1'b0, push} - {1'b0, pop};
        drain_done = (state == S_DRAIN) && !in_flight && (count_nxt == 2'd0);
    end

    // Burst FSM, address/length counters, in-flight tracking and FIFO storage.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state     <= S_IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            in_flight <= 1'b0;
            zero_pend <= 1'b0;
            done_q    <= 1'b0;
            wr_ptr    <= 2'd0;
            rd_ptr    <= 2'd0;
            count     <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            // RAM data for the read issued last cycle is present now.
            in_flight <= issue;
            if (push) begin
                fifo_mem[wr_ptr] <= ram_rdata_i;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count     <= count_nxt;
            done_q    <= zero_pend || drain_done;
            zero_pend <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        if (len_i != '0) begin
                            cur_addr  <= base_i;
                            remaining <= len_i;
                            state     <= S_RUN;
                        end else begin
                            // Empty burst: no reads, just a completion pulse next cycle.
                            zero_pend <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (issue) begin
                        cur_addr  <= cur_addr + addr_width'(1);
                        remaining <= remaining - len_width'(1);
                        if (remaining == len_width'(1)) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_done) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ram_raddr_o = cur_addr;
    assign data_o      = fifo_mem[rd_ptr];
    assign valid_o     = (count != 2'd0);
    assign busy_o      = (state != S_IDLE);
    assign done_o      = done_q;

endmodule

// File: tb/tb_lm32_dp_ram_reader.sv
// Bench for lm32_dp_ram_reader: two instances (32-bit and 4-bit address), behavioural RAM,
// bursts compared against an expected word list built from base/len and the RAM contents.
module tb_lm32_dp_ram_reader;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_a, start_b;
    logic [31:0] base;
    logic [15:0] len;
    logic        ready;

    logic [31:0] raddr_a;
    logic [7:0]  rdata_a, data_a;
    logic        valid_a, busy_a, done_a;
    logic [3:0]  raddr_b;
    logic [7:0]  rdata_b, data_b;
    logic        valid_b, busy_b, done_b;

    lm32_dp_ram_reader u_dut_a (
        .clk_i(clk), .rst_i(rst_n), .start_i(start_a), .base_i(base), .len_i(len),
        .ram_raddr_o(raddr_a), .ram_rdata_i(rdata_a), .data_o(data_a), .valid_o(valid_a),
        .ready_i(ready), .busy_o(busy_a), .done_o(done_a)
    );

    lm32_dp_ram_reader #(.addr_width(4)) u_dut_b (
        .clk_i(clk), .rst_i(rst_n), .start_i(start_b), .base_i(base[3:0]), .len_i(len),
        .ram_raddr_o(raddr_b), .ram_rdata_i(rdata_b), .data_o(data_b), .valid_o(valid_b),
        .ready_i(ready), .busy_o(busy_b), .done_o(done_b)
    );

    // RAM contents: word at address k is k[7:0] xor key.
    logic [7:0] key;
    function automatic logic [7:0] ram_f(input logic [31:0] a);
        return a[7:0] ^ key;
    endfunction

    always @(posedge clk) begin
        rdata_a <= ram_f(raddr_a);
        rdata_b <= ram_f({28'd0, raddr_b});
    end

    int          sel;
    logic [31:0] o_raddr;
    logic [7:0]  o_data;
    logic        o_valid, o_busy, o_done;
    assign o_raddr = (sel != 0) ? {28'd0, raddr_b} : raddr_a;
    assign o_data  = (sel != 0) ? data_b  : data_a;
    assign o_valid = (sel != 0) ? valid_b : valid_a;
    assign o_busy  = (sel != 0) ? busy_b  : busy_a;
    assign o_done  = (sel != 0) ? done_b  : done_a;

    int n_cmp = 0;
    int n_err = 0;

    // Observations collected by the burst driver.
    logic [7:0]  got_q[$];
    int          got_cyc[$];
    logic [31:0] addr_log[$];
    logic [7:0]  exp_q[$];
    int first_valid, done_cyc, done_cnt, unstable, max_out, busy_seen, valid_seen;
    bit timed_out, busy_at_done;

    // Builds the expected word list of a burst from address arithmetic alone.
    function automatic void build_exp(input logic [31:0] b, input int n, input int aw4);
        logic [31:0] a;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            a = b + 32'(i);
            if (aw4 != 0) a = a & 32'hF;
            exp_q.push_back(ram_f(a));
        end
    endfunction

    // Starts a burst on the selected instance and observes it until completion.
    // rmode: 0 = ready high, 1 = random ready, 2 = ready low 5 cycles after 2nd beat.
    task automatic drive_burst(input logic [31:0] b, input int n, input int rmode, input bit inject);
        int          cyc, acc, stall_left;
        bit          stalled, prev_valid, prev_ready;
        logic [7:0]  prev_data;
        logic [31:0] prev_raddr;
        got_q.delete(); got_cyc.delete(); addr_log.delete();
        first_valid = -1; done_cyc = -1; done_cnt = 0; unstable = 0; max_out = 0;
        busy_seen = 0; valid_seen = 0; timed_out = 0; busy_at_done = 1;
        base = b; len = n[15:0];
        ready = 1'b1;
        if (sel != 0) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
        cyc = 0; acc = 0; stall_left = 0; stalled = 0;
        prev_valid = 0; prev_ready = 1; prev_data = 8'd0;
        prev_raddr = o_raddr;
        while (1) begin
            start_a = 1'b0; start_b = 1'b0;
            if (prev_valid && !prev_ready && (!o_valid || o_data !== prev_data)) unstable++;
            if (o_raddr !== prev_raddr) begin
                addr_log.push_back(prev_raddr);
                prev_raddr = o_raddr;
            end
            if (o_busy) busy_seen++;
            if (o_valid) begin
                valid_seen++;
                if (first_valid < 0) first_valid = cyc;
            end
            if (o_done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    busy_at_done = o_busy;
                end
            end
            if (addr_log.size() - acc > max_out) max_out = addr_log.size() - acc;
            case (rmode)
                1: ready = ($urandom_range(0, 1) != 0);
                2: begin
                    if (acc == 2 && !stalled) begin
                        stalled = 1; stall_left = 5;
                    end
                    if (stall_left > 0) begin
                        ready = 1'b0; stall_left--;
                    end else ready = 1'b1;
                end
                default: ready = 1'b1;
            endcase
            if (o_valid && ready) begin
                got_q.push_back(o_data);
                got_cyc.push_back(cyc);
                acc++;
            end
            prev_valid = o_valid; prev_ready = ready; prev_data = o_data;
            if (inject && cyc == 2) begin
                base = 32'h40; len = 16'd3;
                if (sel != 0) start_b = 1'b1; else start_a = 1'b1;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            if (cyc >= 400) begin
                timed_out = 1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start_a = 1'b0; start_b = 1'b0; ready = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start_a = 0; start_b = 0; ready = 1; base = 0; len = 0; sel = 0; key = 0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (valid_a !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid_a); end
        n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        n_cmp++; if (done_a !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done_a); end
        n_cmp++; if (raddr_a !== 32'd0) begin n_err++; $display("FAIL reset_raddr: got %0h want 0", raddr_a); end
        n_cmp++; if (data_a !== 8'd0) begin n_err++; $display("FAIL reset_data: got %0h want 0", data_a); end
        n_cmp++; if (valid_b !== 1'b0 || busy_b !== 1'b0) begin n_err++; $display("FAIL reset_b: got valid %b busy %b want 0 0", valid_b, busy_b); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        sel = 0; key = 8'h00;
        drive_burst(32'h10, 4, 0, 0);
        build_exp(32'h10, 4, 0);
        n_cmp++; if (timed_out) begin n_err++; $display("FAIL basic_timeout: got timeout want done"); end
        n_cmp++; if (first_valid != 2) begin n_err++; $display("FAIL basic_latency: got %0d want 2", first_valid); end
        n_cmp++; if (got_q.size() != 4) begin n_err++; $display("FAIL basic_count: got %0d want 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i] || got_cyc[i] != 2 + i) begin
                n_err++; $display("FAIL basic_beat%0d: got %0h@%0d want %0h@%0d", i, got_q[i], got_cyc[i], exp_q[i], 2 + i);
            end
        end
        n_cmp++; if (done_cyc != 6 || done_cnt != 1) begin n_err++; $display("FAIL basic_done: got cyc %0d cnt %0d want 6 1", done_cyc, done_cnt); end
        n_cmp++; if (busy_at_done !== 1'b0) begin n_err++; $display("FAIL basic_busy_at_done: got %b want 0", busy_at_done); end
    endtask

    task automatic test_zero_len;
        sel = 0;
        drive_burst(32'h55, 0, 0, 0);
        n_cmp++; if (done_cyc != 1 || done_cnt != 1) begin n_err++; $display("FAIL zero_done: got cyc %0d cnt %0d want 1 1", done_cyc, done_cnt); end
        n_cmp++; if (valid_seen != 0) begin n_err++; $display("FAIL zero_valid: got %0d want 0", valid_seen); end
        n_cmp++; if (busy_seen != 0) begin n_err++; $display("FAIL zero_busy: got %0d want 0", busy_seen); end
        n_cmp++; if (addr_log.size() != 0) begin n_err++; $display("FAIL zero_reads: got %0d want 0", addr_log.size()); end
    endtask

    task automatic test_backpressure;
        logic [31:0] b;
        sel = 0; key = 8'($urandom); b = $urandom;
        drive_burst(b, 8, 2, 0);
        build_exp(b, 8, 0);
        n_cmp++; if (got_q != exp_q) begin n_err++; $display("FAIL bp_data: got %0d beats want %0d in order", got_q.size(), exp_q.size()); end
        n_cmp++; if (unstable != 0) begin n_err++; $display("FAIL bp_stable: got %0d changes want 0", unstable); end
        n_cmp++; if (max_out != 3) begin n_err++; $display("FAIL bp_outstanding: got %0d want 3", max_out); end
        n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL bp_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_wrap;
        sel = 1; key = 8'h5A;
        drive_burst(32'hE, 4, 0, 0);
        build_exp(32'hE, 4, 1);
        n_cmp++; if (addr_log.size() != 4) begin n_err++; $display("FAIL wrap_reads: got %0d want 4", addr_log.size()); end
        for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
            n_cmp++; if (addr_log[i] !== ((32'hE + 32'(i)) & 32'hF)) begin
                n_err++; $display("FAIL wrap_addr%0d: got %0h want %0h", i, addr_log[i], (32'hE + 32'(i)) & 32'hF);
            end
        end
        n_cmp++; if (got_q != exp_q) begin n_err++; $display("FAIL wrap_data: got %0d beats want %0d matching", got_q.size(), exp_q.size()); end
        sel = 0;
    endtask

    task automatic test_start_ignored;
        sel = 0; key = 8'h33;
        drive_burst(32'h20, 6, 0, 1);
        build_exp(32'h20, 6, 0);
        n_cmp++; if (got_q != exp_q) begin n_err++; $display("FAIL ign_data: got %0d beats want %0d matching", got_q.size(), exp_q.size()); end
        n_cmp++; if (addr_log.size() != 6 || (addr_log.size() > 0 && addr_log[addr_log.size()-1] !== 32'h25)) begin
            n_err++; $display("FAIL ign_reads: got %0d reads want 6 ending 25", addr_log.size());
        end
        n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL ign_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_reset_mid;
        int bad;
        sel = 0; key = 8'h00;
        base = 32'h80; len = 16'd8; start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        repeat (3) @(posedge clk);
        #1; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        n_cmp++; if (valid_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
            n_err++; $display("FAIL rstmid_outputs: got v%b b%b d%b want 000", valid_a, busy_a, done_a);
        end
        n_cmp++; if (raddr_a !== 32'd0) begin n_err++; $display("FAIL rstmid_raddr: got %0h want 0", raddr_a); end
        bad = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (valid_a || done_a || busy_a) bad++;
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", bad); end
        drive_burst(32'h0, 2, 0, 0);
        build_exp(32'h0, 2, 0);
        n_cmp++; if (got_q != exp_q || first_valid != 2) begin
            n_err++; $display("FAIL rstmid_reburst: got %0d beats first@%0d want 2 beats first@2", got_q.size(), first_valid);
        end
        n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL rstmid_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_random;
        logic [31:0] b;
        int n, aw4;
        for (int it = 0; it < 20; it++) begin
            aw4 = $urandom_range(0, 1);
            sel = aw4;
            key = 8'($urandom);
            b = $urandom;
            n = (aw4 != 0) ? $urandom_range(1, 15) : $urandom_range(1, 20);
            drive_burst(b, n, 1, 0);
            build_exp(b, n, aw4);
            n_cmp++; if (got_q != exp_q) begin
                n_err++; $display("FAIL rand%0d_data: got %0d beats want %0d in order", it, got_q.size(), exp_q.size());
            end
            n_cmp++; if (done_cnt != 1 || timed_out) begin
                n_err++; $display("FAIL rand%0d_done: got cnt %0d timeout %0d want 1 0", it, done_cnt, timed_out);
            end
            n_cmp++; if (unstable != 0 || max_out > 3) begin
                n_err++; $display("FAIL rand%0d_flow: got unstable %0d outstanding %0d want 0 <=3", it, unstable, max_out);
            end
        end
        sel = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_backpressure();
        test_wrap();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
